// File: rtl/sigmon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sigmon_pkg
// Description : Shared constants for the Sigmon event path.
//               - Record field widths.
//               - Flag bit positions inside the 3-bit record flag field.
//               - Fill value used for the data field of non-sample events.
// Revision    : 1.0 - initial release
// ============================================================================
package sigmon_pkg;

    localparam int SIGMON_DATA_W = 48;
    localparam int SIGMON_TS_W   = 32;

    // Bit positions inside the {merged, sample, match} flag field
    localparam int FLG_MATCH  = 0;
    localparam int FLG_SAMPLE = 1;
    localparam int FLG_MERGED = 2;

    localparam logic [SIGMON_DATA_W-1:0] SIGMON_DATA_FILL = 48'h0;

    typedef logic [2:0] sigmon_flags_t;

endpackage
`default_nettype wire

// File: rtl/sigmon_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sigmon_event_arbiter_if
// Description : Valid/ready record stream from the event arbiter to the host
//               event FIFO.
//               master : out_vld, out_src, out_flags, out_data, [out_ts] / out_rdy
//               slave  : the mirror image.
//               out_ts exists only when SIGMON_EVTARB_TIMESTAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface sigmon_event_arbiter_if #(
    parameter int SRC_W = 2
);
    import sigmon_pkg::*;

    logic                     out_vld;
    logic                     out_rdy;
    logic [SRC_W-1:0]         out_src;
    sigmon_flags_t            out_flags;
    logic [SIGMON_DATA_W-1:0] out_data;
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
    logic [SIGMON_TS_W-1:0]   out_ts;
`endif

    modport master (
        output out_vld,
        output out_src,
        output out_flags,
        output out_data,
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
        output out_ts,
`endif
        input  out_rdy
    );

    modport slave (
        input  out_vld,
        input  out_src,
        input  out_flags,
        input  out_data,
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
        input  out_ts,
`endif
        output out_rdy
    );

endinterface
`default_nettype wire

// File: rtl/sigmon_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sigmon_rr_arbiter
// Description : Round-robin arbiter shared by the Sigmon multiplexers.
//               Grants the first requesting index after the last granted one,
//               searching cyclically. The last pointer moves only when the
//               caller accepts a grant (advance with at least one request).
//               Ports: clk, reset (sync, active-high), req, advance,
//                      gnt_onehot, gnt_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module sigmon_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [SRC_W-1:0]   gnt_idx
);

    logic [SRC_W-1:0] r_last;
    logic             w_found;

    always_comb begin
        logic [SRC_W-1:0] v_idx;
        gnt_idx    = '0;
        gnt_onehot = '0;
        w_found    = 1'b0;
        v_idx      = '0;
        // Offsets 1..NUM_SRC: the last winner is examined last
        for (int k = 1; k <= NUM_SRC; k++) begin
            v_idx = SRC_W'((int'(r_last) + k) % NUM_SRC);
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                gnt_idx = v_idx;
            end
        end
        if (w_found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // Reset to the top index so source 0 wins first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= SRC_W'(NUM_SRC - 1);
        end else if (advance && w_found) begin
            r_last <= gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sigmon_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sigmon_event_arbiter
// Description : Collects per-packet match/sample/merged events from NUM_SRC
//               pattern units into one pending slot per source and serializes
//               them round-robin onto a valid/ready record stream. Events
//               arriving at an occupied, non-granted slot are dropped and
//               counted in a saturating 16-bit counter.
//               Ports: clk, reset (sync, active-high), enable, src_match,
//                      src_sample, src_merged, src_sample_data, clear_drops,
//                      drop_count, out_if (record stream, master side).
//               Option: SIGMON_EVTARB_TIMESTAMP_EN adds a free-running 32-bit
//                      timestamp captured at arrival and presented on out_ts.
// Revision    : 1.0 - initial release
// ============================================================================
module sigmon_event_arbiter
    import sigmon_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_SRC-1:0]               src_match,
    input  logic [NUM_SRC-1:0]               src_sample,
    input  logic [NUM_SRC-1:0]               src_merged,
    input  logic [NUM_SRC*SIGMON_DATA_W-1:0] src_sample_data,
    input  logic                             clear_drops,
    output logic [15:0]                      drop_count,
    sigmon_event_arbiter_if.master           out_if
);

    logic [NUM_SRC-1:0]       r_pend;
    sigmon_flags_t            r_flags [NUM_SRC];
    logic [SIGMON_DATA_W-1:0] r_data  [NUM_SRC];
    logic [15:0]              r_drop_count;

    logic [NUM_SRC-1:0]       w_arr;
    logic [NUM_SRC-1:0]       w_take;
    logic [NUM_SRC-1:0]       w_drop;
    logic [NUM_SRC-1:0]       w_granted;
    logic [NUM_SRC-1:0]       w_gnt_onehot;
    logic [SRC_W-1:0]         w_gnt_idx;
    logic                     w_advance;
    logic [16:0]              w_drop_sum;
    logic [16:0]              w_drop_next;

`ifdef SIGMON_EVTARB_TIMESTAMP_EN
    logic [SIGMON_TS_W-1:0]   r_ts_cnt;
    logic [SIGMON_TS_W-1:0]   r_ts [NUM_SRC];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts_cnt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + SIGMON_TS_W'(1);
        end
    end
`endif

    // A slot is taken into the output register whenever the register is
    // empty or being emptied this cycle
    assign w_advance = (|r_pend) && (!out_if.out_vld || out_if.out_rdy);
    assign w_granted = w_advance ? w_gnt_onehot : '0;

    sigmon_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .req        (r_pend),
        .advance    (w_advance),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        sigmon_flags_t w_new_flags;

        assign w_arr[i] = enable & (src_match[i] | src_sample[i] | src_merged[i]);
        // A slot being granted this cycle is free for the new event
        assign w_take[i] = w_arr[i] & (~r_pend[i] | w_granted[i]);
        assign w_drop[i] = w_arr[i] & r_pend[i] & ~w_granted[i];

        assign w_new_flags[FLG_MATCH]  = src_match[i];
        assign w_new_flags[FLG_SAMPLE] = src_sample[i];
        assign w_new_flags[FLG_MERGED] = src_merged[i];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_pend[i]  <= 1'b0;
                r_flags[i] <= '0;
                r_data[i]  <= SIGMON_DATA_FILL;
            end else if (w_take[i]) begin
                r_pend[i]  <= 1'b1;
                r_flags[i] <= w_new_flags;
                r_data[i]  <= src_sample[i] ?
                              src_sample_data[i*SIGMON_DATA_W +: SIGMON_DATA_W] :
                              SIGMON_DATA_FILL;
            end else if (w_granted[i]) begin
                r_pend[i]  <= 1'b0;
            end
        end

`ifdef SIGMON_EVTARB_TIMESTAMP_EN
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ts[i] <= '0;
            end else if (w_take[i]) begin
                r_ts[i] <= r_ts_cnt;
            end
        end
`endif
    end

    // Total drops this cycle; a clear restarts the count from that total
    always_comb begin
        w_drop_sum = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_drop_sum = w_drop_sum + 17'(w_drop[i]);
        end
        if (clear_drops) begin
            w_drop_next = w_drop_sum;
        end else begin
            w_drop_next = {1'b0, r_drop_count} + w_drop_sum;
        end
        if (w_drop_next > 17'h0FFFF) begin
            w_drop_next = 17'h0FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_drop_next[15:0];
        end
    end

    assign drop_count = r_drop_count;

    // Output record register: fields only change on a load, so they hold
    // while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_if.out_vld   <= 1'b0;
            out_if.out_src   <= '0;
            out_if.out_flags <= '0;
            out_if.out_data  <= '0;
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
            out_if.out_ts    <= '0;
`endif
        end else if (w_advance) begin
            out_if.out_vld   <= 1'b1;
            out_if.out_src   <= w_gnt_idx;
            out_if.out_flags <= r_flags[w_gnt_idx];
            out_if.out_data  <= r_data[w_gnt_idx];
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
            out_if.out_ts    <= r_ts[w_gnt_idx];
`endif
        end else if (out_if.out_rdy) begin
            out_if.out_vld   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sigmon_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigmon_event_arbiter
// Description : Self-checking bench for sigmon_event_arbiter. A cycle-level
//               behavioural model (pending slots, last-grant index, output
//               record, drop count) is stepped on every rising edge from the
//               same stimulus; directed scenarios and a randomized run
//               compare the DUT against it and against fixed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigmon_event_arbiter;

    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            clear_drops;
    logic [N-1:0]    src_match;
    logic [N-1:0]    src_sample;
    logic [N-1:0]    src_merged;
    logic [N*48-1:0] src_sample_data;
    logic            rdy;
    logic [15:0]     drop_count;

    int n_vec = 0;
    int n_err = 0;

    sigmon_event_arbiter_if #(.SRC_W(SW)) out_if ();
    assign out_if.out_rdy = rdy;

    sigmon_event_arbiter #(
        .NUM_SRC (N),
        .SRC_W   (SW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .src_match       (src_match),
        .src_sample      (src_sample),
        .src_merged      (src_merged),
        .src_sample_data (src_sample_data),
        .clear_drops     (clear_drops),
        .drop_count      (drop_count),
        .out_if          (out_if)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_pend [N];
    logic [2:0]  m_sflg [N];
    logic [47:0] m_sdat [N];
    int          m_last;
    bit          m_vld;
    int          m_src;
    logic [2:0]  m_flg;
    logic [47:0] m_dat;
    int          m_drops;
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
    logic [31:0] m_sts [N];
    logic [31:0] m_ots;
    logic [31:0] m_tsc;
`endif

    task automatic model_step();
        int g;
        int cnt;
        if (reset) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_last = N - 1; m_vld = 0; m_src = 0; m_flg = 0; m_dat = 0; m_drops = 0;
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
            m_tsc = 0; m_ots = 0;
`endif
            return;
        end
        g = -1;
        for (int k = 1; k <= N; k++)
            if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
        if (g >= 0 && (!m_vld || rdy)) begin
            m_vld = 1; m_src = g; m_flg = m_sflg[g]; m_dat = m_sdat[g];
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
            m_ots = m_sts[g];
`endif
            m_last = g; m_pend[g] = 0;
        end else if (rdy) begin
            m_vld = 0;
        end
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (enable && (src_match[i] || src_sample[i] || src_merged[i])) begin
                if (m_pend[i]) cnt++;
                else begin
                    m_pend[i] = 1;
                    m_sflg[i] = {src_merged[i], src_sample[i], src_match[i]};
                    m_sdat[i] = src_sample[i] ? src_sample_data[i*48 +: 48] : 48'h0;
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
                    m_sts[i] = m_tsc;
`endif
                end
            end
        end
        if (clear_drops) m_drops = cnt;
        else m_drops = (m_drops + cnt > 65535) ? 65535 : m_drops + cnt;
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
        m_tsc = m_tsc + 1;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        src_match = '0; src_sample = '0; src_merged = '0; clear_drops = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // build up pending state and drops, then reset mid-operation
        enable = 1; rdy = 0; reset = 0;
        src_match = '1; tick(); tick(); tick();
        idle_inputs();
        reset = 1; tick(); tick(); reset = 0;
        n_vec++; if (out_if.out_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", out_if.out_vld); end
        n_vec++; if (out_if.out_src !== '0) begin n_err++; $display("FAIL reset_src got %0d want 0", out_if.out_src); end
        n_vec++; if (out_if.out_flags !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", out_if.out_flags); end
        n_vec++; if (out_if.out_data !== 48'h0) begin n_err++; $display("FAIL reset_data got %h want 0", out_if.out_data); end
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drops got %0d want 0", drop_count); end
        // discarded slots must not reappear
        rdy = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++; if (out_if.out_vld !== 1'b0) begin n_err++; $display("FAIL reset_no_stale cyc %0d got vld %b want 0", c, out_if.out_vld); end
        end
    endtask

    task automatic test_single_sample();
        do_reset(); rdy = 1;
        src_sample = 4'b0100;
        src_sample_data = '0;
        src_sample_data[2*48 +: 48] = 48'h0A0B0C0D0E0F;
        tick(); idle_inputs();
        n_vec++; if (out_if.out_vld !== 1'b0) begin n_err++; $display("FAIL single_lat1 got vld %b want 0", out_if.out_vld); end
        tick();
        n_vec++;
        if (out_if.out_vld !== 1'b1 || out_if.out_src !== 2'd2 || out_if.out_flags !== 3'b010 ||
            out_if.out_data !== 48'h0A0B0C0D0E0F) begin
            n_err++;
            $display("FAIL single_rec got vld=%b src=%0d flg=%b data=%h want 1/2/010/0a0b0c0d0e0f",
                     out_if.out_vld, out_if.out_src, out_if.out_flags, out_if.out_data);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(); rdy = 1;
        src_match = '1; tick(); idle_inputs();
        for (int k = 0; k < N; k++) begin
            tick();
            n_vec++;
            if (out_if.out_vld !== 1'b1 || out_if.out_src !== SW'(k) || out_if.out_flags !== 3'b001) begin
                n_err++;
                $display("FAIL simul_rec%0d got vld=%b src=%0d flg=%b want 1/%0d/001",
                         k, out_if.out_vld, out_if.out_src, out_if.out_flags, k);
            end
        end
        tick();
        n_vec++; if (out_if.out_vld !== 1'b0) begin n_err++; $display("FAIL simul_end got vld %b want 0", out_if.out_vld); end
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL simul_drops got %0d want 0", drop_count); end
    endtask

    task automatic test_backpressure();
        do_reset(); rdy = 0;
        for (int t = 0; t < 6; t++) begin
            src_match = (t % 2 == 0 && t < 6) ? 4'b0010 : 4'b0000;
            tick();
        end
        idle_inputs();
        n_vec++;
        if (out_if.out_vld !== 1'b1 || out_if.out_src !== 2'd1 || drop_count !== 16'd1) begin
            n_err++;
            $display("FAIL bp_hold got vld=%b src=%0d drops=%0d want 1/1/1", out_if.out_vld, out_if.out_src, drop_count);
        end
        rdy = 1; tick();
        n_vec++;
        if (out_if.out_vld !== 1'b1 || out_if.out_src !== 2'd1) begin
            n_err++; $display("FAIL bp_second got vld=%b src=%0d want 1/1", out_if.out_vld, out_if.out_src);
        end
        tick();
        n_vec++; if (out_if.out_vld !== 1'b0) begin n_err++; $display("FAIL bp_drain got vld %b want 0", out_if.out_vld); end
    endtask

    task automatic test_collision();
        do_reset(); rdy = 1;
        src_match = 4'b0001; tick(); idle_inputs();
        src_merged = 4'b0001; tick(); idle_inputs();
        n_vec++;
        if (out_if.out_vld !== 1'b1 || out_if.out_src !== 2'd0 || out_if.out_flags !== 3'b001) begin
            n_err++; $display("FAIL coll_first got vld=%b src=%0d flg=%b want 1/0/001", out_if.out_vld, out_if.out_src, out_if.out_flags);
        end
        tick();
        n_vec++;
        if (out_if.out_vld !== 1'b1 || out_if.out_src !== 2'd0 || out_if.out_flags !== 3'b100) begin
            n_err++; $display("FAIL coll_second got vld=%b src=%0d flg=%b want 1/0/100", out_if.out_vld, out_if.out_src, out_if.out_flags);
        end
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL coll_drops got %0d want 0", drop_count); end
    endtask

    task automatic test_saturation();
        do_reset(); rdy = 0;
        src_match = '1;
        repeat (16400) tick();
        n_vec++; if (drop_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_value got %h want ffff", drop_count); end
        n_vec++; if (drop_count !== m_drops[15:0]) begin n_err++; $display("FAIL sat_model got %h want %h", drop_count, m_drops[15:0]); end
        src_match = 4'b0011; clear_drops = 1; tick(); idle_inputs();
        n_vec++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL clear_with_drops got %0d want 2", drop_count); end
    endtask

    task automatic test_enable();
        rdy = 1; idle_inputs();
        repeat (8) tick();
        enable = 0;
        for (int c = 0; c < 20; c++) begin
            src_match  = N'($urandom);
            src_sample = N'($urandom);
            src_merged = N'($urandom);
            tick();
            n_vec++;
            if (out_if.out_vld !== 1'b0 || drop_count !== 16'd2) begin
                n_err++; $display("FAIL enable_off cyc %0d got vld=%b drops=%0d want 0/2", c, out_if.out_vld, drop_count);
            end
        end
        idle_inputs(); enable = 1;
    endtask

`ifdef SIGMON_EVTARB_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset(); rdy = 1;
        repeat (100) tick();
        src_sample = 4'b1000; tick(); idle_inputs(); tick();
        n_vec++;
        if (out_if.out_vld !== 1'b1 || out_if.out_ts !== 32'd100) begin
            n_err++; $display("FAIL ts_100 got vld=%b ts=%0d want 1/100", out_if.out_vld, out_if.out_ts);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] r1, r2;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            clear_drops = ($urandom_range(0, 49) == 0);
            rdy         = ($urandom_range(0, 3) != 0);
            src_match   = N'($urandom & $urandom);
            src_sample  = N'($urandom & $urandom);
            src_merged  = N'($urandom & $urandom & $urandom);
            for (int i = 0; i < N; i++) begin
                r1 = $urandom; r2 = $urandom;
                src_sample_data[i*48 +: 48] = {r1[15:0], r2};
            end
            tick();
            n_vec++;
            if (out_if.out_vld !== m_vld || drop_count !== m_drops[15:0]) begin
                n_err++; $display("FAIL rand_vld_drops cyc %0d got vld=%b drops=%0d want %b/%0d",
                                  c, out_if.out_vld, drop_count, m_vld, m_drops);
            end
            if (m_vld) begin
                n_vec++;
                if (out_if.out_src !== SW'(m_src) || out_if.out_flags !== m_flg || out_if.out_data !== m_dat) begin
                    n_err++; $display("FAIL rand_rec cyc %0d got src=%0d flg=%b data=%h want %0d/%b/%h",
                                      c, out_if.out_src, out_if.out_flags, out_if.out_data, m_src, m_flg, m_dat);
                end
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
                n_vec++;
                if (out_if.out_ts !== m_ots) begin
                    n_err++; $display("FAIL rand_ts cyc %0d got %0d want %0d", c, out_if.out_ts, m_ots);
                end
`endif
            end
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        reset = 1; enable = 1; rdy = 1;
        src_sample_data = '0;
        idle_inputs();
        test_reset();
        test_single_sample();
        test_simultaneous();
        test_backpressure();
        test_collision();
        test_saturation();
        test_enable();
`ifdef SIGMON_EVTARB_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
